// File: rtl/frogger_engine.sv
// frogger_engine: VGA timing counters, frog movement/scoring, car motion and collision detection
module frogger_engine #(
    parameter int                    TOTAL_COLS  = 800,
    parameter int                    TOTAL_ROWS  = 525,
    parameter int                    GAME_WIDTH  = 20,
    parameter int                    GAME_HEIGHT = 15,
    parameter int                    START_X     = 10,
    parameter int                    START_Y     = 14,
    parameter int                    NUM_CARS    = 10,
    parameter logic [NUM_CARS*6-1:0] CAR_SPEED   = {NUM_CARS{6'd1}},
    parameter int                    MAX_X       = 20,
    parameter int                    SLOW_COUNT  = 10000000
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic                    i_HSync,
    input  logic                    i_VSync,
    input  logic                    i_Up_Mvt,
    input  logic                    i_Down_Mvt,
    input  logic                    i_Left_Mvt,
    input  logic                    i_Right_Mvt,
    input  logic [2:0]              i_Bitmap_Data,
    input  logic [NUM_CARS*6-1:0]   i_Init_X,
    input  logic [NUM_CARS*6-1:0]   i_Init_Y,
    output logic                    o_HSync,
    output logic                    o_VSync,
    output logic [9:0]              o_Col_Count,
    output logic [9:0]              o_Row_Count,
    output logic [5:0]              o_Frogger_X,
    output logic [5:0]              o_Frogger_Y,
    output logic [6:0]              o_Score,
    output logic [NUM_CARS*6-1:0]   o_Car_X,
    output logic [NUM_CARS*6-1:0]   o_Car_Y,
    output logic                    o_Collided
);
    localparam int CW = (SLOW_COUNT > 1) ? $clog2(SLOW_COUNT) : 1;

    logic                  hsync_q, vsync_q;
    logic [9:0]            col_q, col_d, row_q, row_d;
    logic [3:0]            mvt_q, mvt_d, mvt_edge;
    logic [5:0]            frog_x_q, frog_x_d, frog_y_q, frog_y_d;
    logic [6:0]            score_q, score_d;
    logic                  init_done_q;
    logic [NUM_CARS*6-1:0] car_x_q, car_x_d, car_y_q, car_y_d;
    logic [CW-1:0]         slow_q, slow_d;
    logic                  collided_q, collided_d;
    logic                  frame_start, col_wrap, slow_wrap;

    // pixel counters: restart at the rising edge of vsync, otherwise raster-scan
    always_comb begin
        frame_start = ~vsync_q & i_VSync;
        col_wrap    = col_q == 10'(TOTAL_COLS - 1);
        col_d       = (frame_start || col_wrap) ? '0 : col_q + 10'd1;
        row_d       = frame_start ? '0 :
                      !col_wrap   ? row_q :
                      (row_q == 10'(TOTAL_ROWS - 1)) ? '0 : row_q + 10'd1;
    end

    // switch edges (up, down, left, right); a held switch only moves once
    always_comb begin
        mvt_d    = {i_Up_Mvt, i_Down_Mvt, i_Left_Mvt, i_Right_Mvt};
        mvt_edge = mvt_d & ~mvt_q;
    end

    // frog: death beats goal beats movement, one move per cycle, clamped to the field
    always_comb begin
        frog_x_d = frog_x_q;
        frog_y_d = frog_y_q;
        score_d  = score_q;
        if (collided_q || i_Bitmap_Data == 3'd2) begin
            frog_x_d = 6'(START_X);
            frog_y_d = 6'(START_Y);
        end else if (i_Bitmap_Data == 3'd4) begin
            score_d  = (score_q == 7'd99) ? score_q : score_q + 7'd1;
            frog_x_d = 6'(START_X);
            frog_y_d = 6'(START_Y);
        end else if (mvt_edge[3]) begin
            frog_y_d = (frog_y_q == '0) ? frog_y_q : frog_y_q - 6'd1;
        end else if (mvt_edge[2]) begin
            frog_y_d = (frog_y_q == 6'(GAME_HEIGHT - 1)) ? frog_y_q : frog_y_q + 6'd1;
        end else if (mvt_edge[1]) begin
            frog_x_d = (frog_x_q == '0) ? frog_x_q : frog_x_q - 6'd1;
        end else if (mvt_edge[0]) begin
            frog_x_d = (frog_x_q == 6'(GAME_WIDTH - 1)) ? frog_x_q : frog_x_q + 6'd1;
        end
    end

    // cars: load once after reset, then step each lane on every slow-counter wrap
    always_comb begin
        slow_wrap = slow_q == CW'(SLOW_COUNT - 1);
        slow_d    = slow_wrap ? '0 : slow_q + CW'(1);
        car_x_d   = car_x_q;
        car_y_d   = car_y_q;
        if (!init_done_q) begin
            car_x_d = i_Init_X;
            car_y_d = i_Init_Y;
        end else if (slow_wrap) begin
            for (int i = 0; i < NUM_CARS; i++)
                car_x_d[i*6+:6] = 6'((7'(car_x_q[i*6+:6]) + 7'(CAR_SPEED[i*6+:6])) % 7'(MAX_X));
        end
    end

    // collision: any car sitting on the frog's current tile
    always_comb begin
        collided_d = 1'b0;
        for (int i = 0; i < NUM_CARS; i++)
            collided_d |= (car_x_q[i*6+:6] == frog_x_q) && (car_y_q[i*6+:6] == frog_y_q);
    end

    // state registers
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            mvt_q       <= '0;
            frog_x_q    <= 6'(START_X);
            frog_y_q    <= 6'(START_Y);
            score_q     <= '0;
            init_done_q <= 1'b0;
            car_x_q     <= '0;
            car_y_q     <= '0;
            slow_q      <= '0;
            collided_q  <= 1'b0;
        end else begin
            hsync_q     <= i_HSync;
            vsync_q     <= i_VSync;
            col_q       <= col_d;
            row_q       <= row_d;
            mvt_q       <= mvt_d;
            frog_x_q    <= frog_x_d;
            frog_y_q    <= frog_y_d;
            score_q     <= score_d;
            init_done_q <= 1'b1;
            car_x_q     <= car_x_d;
            car_y_q     <= car_y_d;
            slow_q      <= slow_d;
            collided_q  <= collided_d;
        end
    end

    assign o_HSync     = hsync_q;
    assign o_VSync     = vsync_q;
    assign o_Col_Count = col_q;
    assign o_Row_Count = row_q;
    assign o_Frogger_X = frog_x_q;
    assign o_Frogger_Y = frog_y_q;
    assign o_Score     = score_q;
    assign o_Car_X     = car_x_q;
    assign o_Car_Y     = car_y_q;
    assign o_Collided  = collided_q;
endmodule

// File: tb/tb_frogger_engine.sv
// tb_frogger_engine: scoreboard bench for frogger_engine (3 cars, fast car clock)
module tb_frogger_engine;
    localparam int NC = 3;

    logic          clk, rst_n;
    logic          hs, vs, up, dn, lf, rt;
    logic [2:0]    bmp;
    logic [NC*6-1:0] init_x, init_y;
    logic          o_hs, o_vs, o_coll;
    logic [9:0]    o_col, o_row;
    logic [5:0]    o_fx, o_fy;
    logic [6:0]    o_score;
    logic [NC*6-1:0] o_cx, o_cy;

    frogger_engine #(
        .NUM_CARS  (NC),
        .CAR_SPEED ({6'd0, 6'd3, 6'd1}),
        .SLOW_COUNT(4)
    ) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_HSync(hs), .i_VSync(vs),
        .i_Up_Mvt(up), .i_Down_Mvt(dn), .i_Left_Mvt(lf), .i_Right_Mvt(rt),
        .i_Bitmap_Data(bmp), .i_Init_X(init_x), .i_Init_Y(init_y),
        .o_HSync(o_hs), .o_VSync(o_vs), .o_Col_Count(o_col), .o_Row_Count(o_row),
        .o_Frogger_X(o_fx), .o_Frogger_Y(o_fy), .o_Score(o_score),
        .o_Car_X(o_cx), .o_Car_Y(o_cy), .o_Collided(o_coll)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0, n_bad = 0;
    int          sel_q[$];
    logic [31:0] exp_q[$];
    string       name_q[$];

    function automatic logic [31:0] actual(input int s);
        case (s)
            0: return 32'(o_col);
            1: return 32'(o_row);
            2: return 32'(o_fx);
            3: return 32'(o_fy);
            4: return 32'(o_score);
            5: return 32'(o_coll);
            6: return 32'(o_cx);
            7: return 32'(o_cy);
            8: return 32'(o_vs);
            9: return 32'(o_hs);
            default: return '1;
        endcase
    endfunction

    task automatic chk(input int s, input logic [31:0] e, input string n);
        sel_q.push_back(s);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic chk_frog(input int x, input int y, input string n);
        chk(2, 32'(x), {n, "_x"});
        chk(3, 32'(y), {n, "_y"});
    endtask

    // monitor: drains pending expectations while outputs are stable
    int          m_sel;
    logic [31:0] m_exp, m_act;
    string       m_name;
    always @(negedge clk) begin
        while (sel_q.size() > 0) begin
            m_sel  = sel_q.pop_front();
            m_exp  = exp_q.pop_front();
            m_name = name_q.pop_front();
            m_act  = actual(m_sel);
            n_cmp++;
            if (m_act !== m_exp) begin
                n_bad++;
                $display("FAIL %s: got %0d, expected %0d", m_name, m_act, m_exp);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic u, input logic d, input logic l, input logic r);
        up = u; dn = d; lf = l; rt = r;
        tick;
        up = 0; dn = 0; lf = 0; rt = 0;
        tick;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 0; hs = 0; vs = 0; up = 0; dn = 0; lf = 0; rt = 0; bmp = 3'd0;
        init_x = {6'd5, 6'd18, 6'd19};
        init_y = {6'd32, 6'd31, 6'd30};
        repeat (3) tick;
        chk(0, 0, "rst_col"); chk(1, 0, "rst_row");
        chk_frog(10, 14, "rst_frog");
        chk(4, 0, "rst_score"); chk(5, 0, "rst_coll");
        chk(6, 0, "rst_carx"); chk(7, 0, "rst_cary");
        chk(8, 0, "rst_vs"); chk(9, 0, "rst_hs");
        tick;
        rst_n = 1;
        tick;
        chk(6, 32'({6'd5, 6'd18, 6'd19}), "load_carx");
        chk(7, 32'({6'd32, 6'd31, 6'd30}), "load_cary");
        tick; tick;
        chk(6, 32'({6'd5, 6'd18, 6'd19}), "pre_wrap_carx");
        tick;
        chk(6, 32'({6'd5, 6'd1, 6'd0}), "wrap1_carx");
        repeat (4) tick;
        chk(6, 32'({6'd5, 6'd4, 6'd1}), "wrap2_carx");
        chk(7, 32'({6'd32, 6'd31, 6'd30}), "hold_cary");

        hs = 1; vs = 1;
        tick;
        chk(0, 0, "fs_col"); chk(1, 0, "fs_row");
        chk(8, 1, "vs_lag_hi"); chk(9, 1, "hs_lag_hi");
        hs = 0; vs = 0;
        tick;
        chk(0, 1, "col_1"); chk(8, 0, "vs_lag_lo"); chk(9, 0, "hs_lag_lo");
        repeat (798) tick;
        chk(0, 799, "col_799"); chk(1, 0, "row_0");
        tick;
        chk(0, 0, "col_wrap"); chk(1, 1, "row_inc");

        up = 1;
        tick;
        chk_frog(10, 13, "up1");
        repeat (4) tick;
        chk_frog(10, 13, "up_hold");
        up = 0;
        tick;
        up = 1; lf = 1;
        tick;
        chk_frog(10, 12, "up_left");
        tick;
        chk_frog(10, 12, "up_left_hold");
        up = 0; lf = 0;
        tick;
        press(0, 1, 0, 1);
        chk_frog(10, 13, "down_right");

        repeat (9) press(0, 0, 0, 1);
        repeat (8) press(1, 0, 0, 0);
        chk_frog(19, 5, "at_19_5");
        press(0, 0, 0, 1);
        chk_frog(19, 5, "right_edge");
        repeat (19) press(0, 0, 1, 0);
        repeat (5) press(1, 0, 0, 0);
        chk_frog(0, 0, "at_0_0");
        press(1, 0, 0, 0);
        chk_frog(0, 0, "top_edge");
        press(0, 0, 1, 0);
        chk_frog(0, 0, "left_edge");

        bmp = 3'd4;
        tick;
        chk(4, 1, "score_1"); chk_frog(10, 14, "goal_start");
        repeat (98) tick;
        chk(4, 99, "score_99");
        tick;
        chk(4, 99, "score_sat");
        bmp = 3'd0;
        press(1, 0, 0, 0);
        bmp = 3'd4;
        tick;
        chk(4, 99, "score_sat2"); chk_frog(10, 14, "goal_sat_start");
        bmp = 3'd0;
        press(1, 0, 0, 0);
        chk_frog(10, 13, "pre_water");
        bmp = 3'd2;
        tick;
        chk_frog(10, 14, "water_start"); chk(4, 99, "water_score");
        bmp = 3'd0;
        press(1, 0, 0, 0);

        rst_n = 0;
        chk_frog(10, 14, "async_frog");
        chk(4, 0, "async_score"); chk(6, 0, "async_carx"); chk(0, 0, "async_col");
        init_x = {6'd10, 6'd18, 6'd19};
        init_y = {6'd13, 6'd31, 6'd30};
        tick; tick;
        rst_n = 1;
        tick;
        chk(6, 32'({6'd10, 6'd18, 6'd19}), "reload_carx");
        chk(5, 0, "no_coll");
        up = 1;
        tick;
        chk_frog(10, 13, "onto_car"); chk(5, 0, "coll_latency");
        tick;
        chk(5, 1, "coll_set"); chk_frog(10, 13, "coll_frog");
        tick;
        chk_frog(10, 14, "coll_start"); chk(4, 0, "coll_score");
        tick;
        chk(5, 0, "coll_clear");
        up = 0;
        tick;

        @(negedge clk);
        #1;
        if (sel_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", sel_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/frogger_engine.md
FROGGER_ENGINE -- requirements
Module: frogger_engine

Interface
REQ-001 Parameter TOTAL_COLS, default 800: VGA columns per line, blanking included.
REQ-002 Parameter TOTAL_ROWS, default 525: VGA lines per frame.
REQ-003 Parameter GAME_WIDTH, default 20: playfield width in tiles.
REQ-004 Parameter GAME_HEIGHT, default 15: playfield height in tiles.
REQ-005 Parameter START_X, default 10: frog start column. Parameter START_Y, default 14: frog start row.
REQ-006 Parameter NUM_CARS, default 10: number of cars.
REQ-007 Parameter CAR_SPEED, default all 1: packed NUM_CARS x 6-bit tiles per step; car i uses bits [i*6+:6].
REQ-008 Parameter MAX_X, default 20: car X wrap modulus.
REQ-009 Parameter SLOW_COUNT, default 10000000: clocks per car step.
REQ-010 Ports, clock and reset first (name, direction, width, meaning):
- i_Clk, in, 1: sole clock; all logic on its rising edge.
- i_Rst_L, in, 1: asynchronous, active-low reset.
- i_HSync, in, 1: raw horizontal sync.
- i_VSync, in, 1: raw vertical sync.
- i_Up_Mvt, in, 1: up switch, level.
- i_Down_Mvt, in, 1: down switch, level.
- i_Left_Mvt, in, 1: left switch, level.
- i_Right_Mvt, in, 1: right switch, level.
- i_Bitmap_Data, in, 3: tile code at (o_Frogger_Y, o_Frogger_X), combinational from external map. Codes: 0 wall, 1 road, 2 water, 3 safe, 4 lily pad.
- i_Init_X, in, NUM_CARS*6: packed initial car columns.
- i_Init_Y, in, NUM_CARS*6: packed car lanes.
- o_HSync, out, 1: i_HSync delayed 1 clock.
- o_VSync, out, 1: i_VSync delayed 1 clock.
- o_Col_Count, out, 10: pixel column.
- o_Row_Count, out, 10: pixel row.
- o_Frogger_X, out, 6: frog tile column.
- o_Frogger_Y, out, 6: frog tile row.
- o_Score, out, 7: score, 0..99.
- o_Car_X, out, NUM_CARS*6: packed car columns.
- o_Car_Y, out, NUM_CARS*6: packed car lanes.
- o_Collided, out, 1: registered frog/car overlap flag.

Function
REQ-011 Frame start is defined as o_VSync==0 and i_VSync==1 in the same cycle. On frame start, o_Col_Count and o_Row_Count SHALL be set to 0.
REQ-012 When not at frame start, o_Col_Count SHALL increment each clock. At TOTAL_COLS-1 it wraps to 0 and o_Row_Count increments. o_Row_Count at TOTAL_ROWS-1 wraps to 0 on the same column wrap.
REQ-013 Each movement input SHALL be registered, and only a 0->1 edge requests a move. Holding a switch high produces exactly one move.
REQ-014 A move SHALL change the frog position by one tile: up Y-1, down Y+1, left X-1, right X+1. The result is clamped to 0..GAME_WIDTH-1 and 0..GAME_HEIGHT-1; a move at an edge leaves the position unchanged.
REQ-015 When several edges occur in the same cycle, only one move SHALL apply, with priority up > down > left > right.
REQ-016 Per-cycle frog priority SHALL be: (1) o_Collided==1 or i_Bitmap_Data==2 sends the frog to (START_X, START_Y), score unchanged; (2) i_Bitmap_Data==4 increments the score (saturating at 99) and sends the frog to start; (3) a move request is applied. A lower-priority event in the same cycle is discarded.
REQ-017 Car positions SHALL be loaded from i_Init_X and i_Init_Y on the first clock after reset release. After that, o_Car_Y is held constant.
REQ-018 A free-running counter SHALL count 0..SLOW_COUNT-1. When it wraps, every car i SHALL update X_i <= (X_i + CAR_SPEED_i) mod MAX_X. The counter restarts at 0 on reset.
REQ-019 o_Collided SHALL be 1 on the clock after any car has X==o_Frogger_X and Y==o_Frogger_Y, and 0 otherwise (one-cycle latency).
REQ-020 All arithmetic SHALL be unsigned. The car X sum is computed in 7 bits before the modulo so it cannot overflow.

Reset
REQ-021 While i_Rst_L==0, the outputs SHALL hold these values:
- o_Col_Count = 0, o_Row_Count = 0;
- o_HSync = 0, o_VSync = 0;
- o_Frogger_X = START_X, o_Frogger_Y = START_Y;
- o_Score = 0, o_Collided = 0;
- o_Car_X = 0, o_Car_Y = 0;
- edge-detect registers cleared;
- init-done flag cleared.
REQ-022 Reset asserted mid-operation SHALL take effect immediately without a clock edge. Cars reload from i_Init_X/i_Init_Y on the first clock after reset release.

Verification
REQ-023 Hold i_VSync low, then pulse it high, then run 800 clocks -> counts reach col 0 / row 0 at the edge; col wraps 799->0 with row 0->1; o_VSync lags i_VSync by 1 clock.
REQ-024 From reset, raise i_Up_Mvt and hold it 5 clocks -> frog at (10,13) exactly once. Raise i_Up_Mvt and i_Left_Mvt in the same cycle -> only Y decrements.
REQ-025 Frog at (19,5), raise i_Right_Mvt -> position unchanged. Frog at (0,0), raise up then left -> unchanged.
REQ-026 SLOW_COUNT=4, CAR_SPEED all 1, i_Init_X car0=19 -> car0 X goes 19->0 on the first counter wrap. A car with speed 3 at X=18 -> X=1.
REQ-027 Place a car on the frog tile -> o_Collided=1 one clock later, then frog at (10,14) the following clock, score unchanged.
REQ-028 Set i_Bitmap_Data=4 at score 99 -> score stays 99 and frog returns to start. Set i_Bitmap_Data=2 -> frog returns to start, score unchanged.
